// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-port line-granular data memory.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int MAX_CH_W  = 8;
   localparam int MAX_IDX_W = 32;

   function automatic int off_w(input int line_w);
      return $clog2(line_w / 8);
   endfunction

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

   // Fields are sized for the largest build; users slice down to their own widths.
   typedef struct packed {
      logic [MAX_CH_W-1:0]  ch;
      logic                 rw;
      logic [MAX_IDX_W-1:0] idx;
   } req_lat_t;

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NUM_CH requests while enabled; the pointer
// moves to the channel after the winner so every requester is served in turn.
module dmem_rr_arbiter #(
   parameter int NUM_CH = 2,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] req,
   input  logic              enable,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_ch
);

   logic [CH_W-1:0] ptr;
   logic [CH_W-1:0] ptr_next;
   logic [CH_W-1:0] cand;
   logic            found;

   always_comb begin
      grant    = '0;
      grant_ch = '0;
      ptr_next = ptr;
      found    = 1'b0;
      cand     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = CH_W'((int'(ptr) + i) % NUM_CH);
         if (!found && req[cand]) begin
            found    = 1'b1;
            grant    = NUM_CH'(1) << cand;
            grant_ch = cand;
            ptr_next = CH_W'((int'(cand) + 1) % NUM_CH);
         end
      end
      if (!enable) begin
         grant = '0;
         found = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         ptr <= '0;
      else if (found)
         ptr <= ptr_next;
   end

endmodule

// File: rtl/dmem_multiport_store.sv
// Shared line memory, NUM_CH requesters, round-robin; response LATENCY cycles after grant,
// one access in flight (1 per LATENCY+1 cycles). Optional trace: define DMEM_TRACE_EN.
module dmem_multiport_store #(
   parameter int NUM_CH  = 2,
   parameter int LINE_W  = 128,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 5
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        req_valid,
   input  logic [NUM_CH-1:0]        req_rw,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*LINE_W-1:0] req_wdata,
   output logic [NUM_CH-1:0]        req_grant,
   output logic [NUM_CH-1:0]        rsp_ready,
   output logic [LINE_W-1:0]        rsp_data,
   output logic                     busy
);
   import dmem_pkg::*;

   localparam int OFF_W = off_w(LINE_W);
   localparam int IDX_W = idx_w(DEPTH);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t            state, state_next;
   req_lat_t          lat;
   logic [LINE_W-1:0] lat_wdata;
   logic [CNT_W-1:0]  cnt, cnt_dec;
   logic [LINE_W-1:0] mem [DEPTH];

   logic              arb_en;
   logic              gnt_any;
   logic [CH_W-1:0]   gnt_ch;
   logic              gnt_rw;
   logic [IDX_W-1:0]  gnt_idx;
   logic [LINE_W-1:0] gnt_wdata;
   logic [CH_W-1:0]   lat_ch;
   logic [IDX_W-1:0]  lat_idx;
   logic              unused_bits;

   // Grant is combinational, so it must be suppressed while reset is asserted.
   assign arb_en  = (state == IDLE) && !reset;
   assign gnt_any = |req_grant;
   assign lat_ch  = lat.ch[CH_W-1:0];
   assign lat_idx = lat.idx[IDX_W-1:0];
   assign unused_bits = ^{req_addr, lat.ch, lat.idx};

   dmem_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clock    (clock),
      .reset    (reset),
      .req      (req_valid),
      .enable   (arb_en),
      .grant    (req_grant),
      .grant_ch (gnt_ch)
   );

   always_comb begin
      gnt_rw    = 1'b0;
      gnt_idx   = '0;
      gnt_wdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (req_grant[c]) begin
            gnt_rw    = req_rw[c];
            gnt_idx   = req_addr[c*ADDR_W + OFF_W +: IDX_W];
            gnt_wdata = req_wdata[c*LINE_W +: LINE_W];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // cnt holds the WAIT cycles still to go; leave WAIT when the decremented value hits zero.
   always_comb begin
      state_next = state;
      cnt_dec    = cnt - CNT_W'(1);
      unique case (state)
         IDLE:    if (gnt_any) state_next = (LATENCY == 1) ? RESP : WAIT;
         WAIT:    if (cnt_dec == '0) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rsp_ready = '0;
      rsp_data  = '0;
      busy      = gnt_any || (state != IDLE);
      if (state == RESP) begin
         rsp_ready = NUM_CH'(1) << lat_ch;
         if (!lat.rw)
            rsp_data = mem[lat_idx];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat       <= '0;
         lat_wdata <= '0;
         cnt       <= '0;
      end else if (gnt_any) begin
         lat.ch    <= MAX_CH_W'(gnt_ch);
         lat.rw    <= gnt_rw;
         lat.idx   <= MAX_IDX_W'(gnt_idx);
         lat_wdata <= gnt_wdata;
         cnt       <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT) begin
         cnt <= cnt_dec;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && state == RESP && lat.rw)
         mem[lat_idx] <= lat_wdata;
   end

`ifdef DMEM_TRACE_EN
   always_ff @(posedge clock) begin
      if (!reset && state == RESP)
         $display("%0t dmem ch%0d %s idx=%0d addr=0x%0h data=0x%0h", $time, lat_ch,
                  lat.rw ? "W" : "R", lat_idx, ADDR_W'(lat_idx) << OFF_W,
                  lat.rw ? lat_wdata : mem[lat_idx]);
   end
`else
   // Trace compiled out; cycle behaviour is identical.
`endif

endmodule

// File: tb/tb_dmem_multiport_store.sv
// Scoreboarded random + directed bench for dmem_multiport_store (default parameters).
module tb_dmem_multiport_store;
   localparam int NCH = 2, LW = 128, DEP = 1024, AW = 32, LAT = 5;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [NCH-1:0]    req_valid = '0;
   logic [NCH-1:0]    req_rw = '0;
   logic [NCH*AW-1:0] req_addr = '0;
   logic [NCH*LW-1:0] req_wdata = '0;
   logic [NCH-1:0]    req_grant, rsp_ready;
   logic [LW-1:0]     rsp_data;
   logic              busy;

   dmem_multiport_store dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(req_grant),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   typedef struct {
      int          ch;
      bit          rw;
      int          idx;
      logic [LW-1:0] wdata;
      int          due;
   } exp_t;

   exp_t          q[$];
   int            gorder[$];
   logic [LW-1:0] model_mem [DEP];
   bit            known [DEP];
   int            ptr = 0;
   int            errors = 0;
   int            checks = 0;

   function automatic int idx_of(input logic [AW-1:0] a);
      return int'((a >> 4) & (DEP - 1));
   endfunction

   function automatic logic [LW-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      int idx;
      idx = $urandom_range(2, 6);
      return ($urandom & 32'hFFFF_C000) | (AW'(idx) << 4) | AW'($urandom_range(0, 15));
   endfunction

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: service is serial, so the first valid channel from the RR pointer wins
   // whenever nothing is outstanding; its response is due LAT cycles later.
   always @(negedge clock) begin : recorder
      int   win;
      int   c;
      exp_t e;
      if (reset) begin
         chk("grant_in_reset", LW'(req_grant), '0);
      end else begin
         win = -1;
         if (q.size() == 0)
            for (int k = 0; k < NCH; k++) begin
               c = (ptr + k) % NCH;
               if (win < 0 && req_valid[c]) win = c;
            end
         chk("grant", LW'(req_grant), (win >= 0) ? (LW'(1) << win) : '0);
         if (win >= 0) begin
            e.ch    = win;
            e.rw    = req_rw[win];
            e.idx   = idx_of(req_addr[win*AW +: AW]);
            e.wdata = req_wdata[win*LW +: LW];
            e.due   = cyc + LAT;
            q.push_back(e);
            gorder.push_back(win);
            ptr = (win + 1) % NCH;
         end
      end
   end

   always @(negedge clock) begin : monitor
      exp_t e;
      #1;
      if (reset) begin
         chk("rsp_in_reset", LW'(rsp_ready), '0);
         chk("busy_in_reset", LW'(busy), '0);
      end else begin
         chk("busy", LW'(busy), LW'(q.size() != 0));
         if (rsp_ready != '0) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got rsp_ready=%b expected none", rsp_ready);
            end else begin
               e = q.pop_front();
               chk("rsp_cycle", LW'(cyc), LW'(e.due));
               chk("rsp_ch", LW'(rsp_ready), LW'(1) << e.ch);
               if (e.rw) begin
                  chk("rsp_data_write", rsp_data, '0);
                  model_mem[e.idx] = e.wdata;
                  known[e.idx] = 1'b1;
               end else if (known[e.idx]) begin
                  chk("rsp_read_data", rsp_data, model_mem[e.idx]);
               end
            end
         end else begin
            chk("rsp_data_idle", rsp_data, '0);
            if (q.size() != 0 && cyc >= q[0].due) begin
               checks++;
               errors++;
               $display("FAIL rsp_missing: got no rsp_ready expected ch%0d at cycle %0d", q[0].ch, q[0].due);
               void'(q.pop_front());
            end
         end
      end
   end

   // Called at posedge+1; inputs are scrambled right after the grant edge.
   task automatic issue(input int ch, input bit rw, input logic [AW-1:0] a,
                        input logic [LW-1:0] d, input bit hold, output bit got);
      int n;
      got = 1'b0;
      n = 0;
      req_rw[ch] = rw;
      req_addr[ch*AW +: AW] = a;
      req_wdata[ch*LW +: LW] = d;
      req_valid[ch] = 1'b1;
      while (!got && n < 300) begin
         @(negedge clock);
         got = req_grant[ch];
         n++;
         if (!hold) break;
      end
      @(posedge clock);
      #1;
      req_valid[ch] = 1'b0;
      req_rw[ch] = $urandom_range(0, 1);
      req_addr[ch*AW +: AW] = $urandom;
      req_wdata[ch*LW +: LW] = rand128();
      if (hold) begin
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL grant_timeout: got no grant for ch%0d expected one within 300 cycles", ch);
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clock);
         n++;
      end
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int hold_cycles);
      reset = 1'b1;
      #1;
      chk("reset_busy", LW'(busy), '0);
      chk("reset_rsp_ready", LW'(rsp_ready), '0);
      chk("reset_grant", LW'(req_grant), '0);
      chk("reset_rsp_data", rsp_data, '0);
      q.delete();
      ptr = 0;
      repeat (hold_cycles) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic rand_driver(input int ch, input int n);
      bit got;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clock);
         #1;
         issue(ch, 1'($urandom_range(0, 1)), rand_addr(), rand128(), $urandom_range(0, 4) != 0, got);
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no completion expected finish before 40000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      bit got;
      for (int i = 0; i < DEP; i++) known[i] = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      do_reset(2);

      // Write a line then read it back on ch0.
      issue(0, 1'b1, 32'h40, {4{32'hDEADBEEF}}, 1'b1, got);
      issue(0, 1'b0, 32'h40, '0, 1'b1, got);
      wait_idle();

      // Simultaneous requests from reset: ch0, ch1, ch0, ch1.
      do_reset(2);
      gorder.delete();
      fork
         issue(0, 1'b0, 32'h40, '0, 1'b1, got);
         issue(1, 1'b1, 32'h90, {4{32'h1234_5678}}, 1'b1, got);
      join
      fork
         issue(0, 1'b1, 32'hA0, {4{32'hCAFE_F00D}}, 1'b1, got);
         issue(1, 1'b0, 32'h90, '0, 1'b1, got);
      join
      wait_idle();
      chk("order_len", LW'(gorder.size()), LW'(4));
      for (int i = 0; i < 4 && i < gorder.size(); i++)
         chk("order", LW'(gorder[i]), LW'(i % 2));

      // Data captured at grant only (issue scrambles inputs afterwards).
      issue(1, 1'b1, 32'h80, {32'h0101_0101, 32'h2020_2020, 32'h0303_0303, 32'h4040_4040}, 1'b1, got);
      issue(1, 1'b0, 32'h8F, '0, 1'b1, got);
      wait_idle();

      // Aliasing: 0x4040 maps onto the same line as 0x40.
      issue(0, 1'b1, 32'h40, {4{32'hAAAA_5555}}, 1'b1, got);
      issue(0, 1'b1, 32'h4040, {4{32'h5A5A_A5A5}}, 1'b1, got);
      issue(1, 1'b0, 32'h40, '0, 1'b1, got);
      wait_idle();
      chk("alias_idx", LW'(idx_of(32'h4040)), LW'(4));

      // Reset during WAIT of a write: the write must not land.
      issue(0, 1'b1, 32'h40, {4{32'hBAD0_BAD0}}, 1'b1, got);
      @(posedge clock);
      #1;
      do_reset(2);
      issue(1, 1'b0, 32'h40, '0, 1'b1, got);
      wait_idle();

      // Randomised contention with aliasing addresses and dropped requests.
      fork
         rand_driver(0, 40);
         rand_driver(1, 40);
      join
      wait_idle();
      chk("queue_drained", LW'(q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
